// File: rtl/jcpu_pkg.sv
// ============================================================================
// jcpu_pkg -- shared FSM encoding and phase table for the CPU clock controller
// Rev 1.0
// ============================================================================
`default_nettype none

package jcpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_SINSTR = 3'd2,
        ST_SCYC   = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam logic [1:0] PH_P0      = 2'd0;
    localparam logic [1:0] PH_P3      = 2'd3;
    localparam logic [2:0] STEP_FIRST = 3'd0;
    localparam logic [2:0] STEP_LAST  = 3'd5;
    localparam logic [0:5] BOS_FIRST  = 6'b100000;

    // {wclk, wclkd} driven while the phase counter sits at ph
    function automatic logic [1:0] phase_clks(input logic [1:0] ph);
        logic [1:0] clks;
        case (ph)
            2'd0:    clks = 2'b10;
            2'd1:    clks = 2'b11;
            2'd2:    clks = 2'b01;
            default: clks = 2'b00;
        endcase
        return clks;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jphase_gen.sv
// ============================================================================
// jphase_gen -- DIV prescaler plus 2-bit phase counter with registered clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module jphase_gen
    import jcpu_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic wrap,
    output logic wclk,
    output logic wclkd,
    output logic wclke,
    output logic wclks
);

    localparam logic [7:0] PRE_LAST = 8'(DIV - 1);
    localparam logic [1:0] P0_CLKS  = phase_clks(PH_P0);

    logic [7:0] r_pre;
    logic [1:0] r_phase;
    logic       w_tick;
    logic [1:0] w_next;
    logic [1:0] w_clks;

    assign w_tick = en && (r_pre == PRE_LAST);
    assign w_next = r_phase + 2'd1;
    assign w_clks = phase_clks(w_next);
    assign wrap   = w_tick && (r_phase == PH_P3);

    // All four clock outputs load from the next phase, so none of them is a
    // combinational decode that could glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= 8'd0;
            r_phase <= PH_P0;
            wclk    <= P0_CLKS[1];
            wclkd   <= P0_CLKS[0];
            wclke   <= |P0_CLKS;
            wclks   <= &P0_CLKS;
        end else if (!en) begin
            r_pre <= 8'd0;
        end else if (w_tick) begin
            r_pre   <= 8'd0;
            r_phase <= w_next;
            wclk    <= w_clks[1];
            wclkd   <= w_clks[0];
            wclke   <= |w_clks;
            wclks   <= &w_clks;
        end else begin
            r_pre <= r_pre + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/jstep_ctl.sv
// ============================================================================
// jstep_ctl -- run / single-instruction / single-cycle controller for CPU phases
// Rev 1.0
// ============================================================================
`default_nettype none

module jstep_ctl
    import jcpu_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        step_instr,
    input  logic        step_cycle,
    input  logic        halt,
    output logic        wclk,
    output logic        wclkd,
    output logic        wclke,
    output logic        wclks,
    output logic [0:5]  bos,
    output logic        running,
    output logic [15:0] icount
);

    state_t     r_state;
    logic [2:0] r_step;
    logic       w_active;
    logic       w_wrap;
    logic       w_boundary;
    logic       w_cmd_ok;

    assign w_active   = (r_state != ST_IDLE);
    assign w_boundary = w_wrap && (r_step == STEP_LAST);
    assign w_cmd_ok   = !halt && !(start && stop);

    jphase_gen #(
        .DIV   (DIV)
    ) u_phase (
        .clk   (clk),
        .reset (reset),
        .en    (w_active),
        .wrap  (w_wrap),
        .wclk  (wclk),
        .wclkd (wclkd),
        .wclke (wclke),
        .wclks (wclks)
    );

    // Every exit to IDLE happens on a phase wrap, so the phase generator is
    // already back at p0 when its enable drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_step  <= STEP_FIRST;
            bos     <= BOS_FIRST;
            running <= 1'b0;
            icount  <= 16'd0;
        end else begin
            if (w_wrap) begin
                r_step <= w_boundary ? STEP_FIRST : r_step + 3'd1;
                bos    <= {bos[5], bos[0:4]};
            end
            if (w_boundary) begin
                icount <= icount + 16'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_ok) begin
                        if (start) begin
                            r_state <= ST_RUN;
                            running <= 1'b1;
                        end else if (step_instr) begin
                            r_state <= ST_SINSTR;
                            running <= 1'b1;
                        end else if (step_cycle) begin
                            r_state <= ST_SCYC;
                            running <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop || halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_SINSTR, ST_DRAIN: begin
                    if (w_boundary) begin
                        r_state <= ST_IDLE;
                        running <= 1'b0;
                    end
                end
                ST_SCYC: begin
                    if (w_wrap) begin
                        r_state <= ST_IDLE;
                        running <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/jstep_ctl.md
JSTEP_CTL -- requirements
Module: jstep_ctl

Interface
REQ-001 SHALL have parameter DIV, default 1: system clocks per phase advance (legal 1..255).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  pulse: enter continuous run.
REQ-005 SHALL have port stop  input  1  pulse: halt at next instruction boundary.
REQ-006 SHALL have port step_instr  input  1  pulse: run exactly one instruction (6 steps).
REQ-007 SHALL have port step_cycle  input  1  pulse: run exactly one clock cycle (4 phases).
REQ-008 SHALL have port halt  input  1  level from CPU: request stop at instruction boundary.
REQ-009 SHALL have port wclk, wclkd, wclke, wclks  output  1 each  CPU clock phases.
REQ-010 SHALL have port bos  output  [0:5]  one-hot step, bos[0] = step 1.
REQ-011 SHALL have port running  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port icount  output  16  count of completed instructions.

Function
REQ-013 SHALL hold a 2-bit phase p with (wclk,wclkd) = p0:(1,0), p1:(1,1), p2:(0,1), p3:(0,0), then back to p0.
REQ-014 SHALL drive wclke = wclk OR wclkd and wclks = wclk AND wclkd, all four from registers, glitch-free.
REQ-015 SHALL advance p by one every DIV clk cycles, only when not IDLE; prescaler clears on entering IDLE.
REQ-016 SHALL advance the step index (0..5) only on the p3->p0 transition; 5 wraps to 0.
REQ-017 SHALL keep bos exactly one-hot at all times, including IDLE.
REQ-018 SHALL increment icount on the step-5->step-0 wrap; 0xFFFF wraps to 0x0000.
REQ-019 SHALL implement FSM states IDLE, RUN, SINSTR, SCYC, DRAIN.
REQ-020 IDLE: start -> RUN; step_instr -> SINSTR; step_cycle -> SCYC; priority start > step_instr > step_cycle.
REQ-021 RUN: stop or halt -> DRAIN; otherwise stay.
REQ-022 SINSTR: on step-5->0 wrap -> IDLE.
REQ-023 SCYC: on the next p3->p0 transition -> IDLE; if that transition is the step-5 wrap, icount increments.
REQ-024 DRAIN: on step-5->0 wrap -> IDLE; start ignored while in DRAIN.
REQ-025 In IDLE, outputs SHALL freeze at p0 (wclk=1, wclkd=0) with the current step held.
REQ-026 SHALL ignore start, step_instr and step_cycle while not IDLE.
REQ-027 SHALL ignore all three pulses in IDLE while halt=1.
REQ-028 If stop and start arrive together in IDLE, the FSM SHALL stay IDLE (stop wins).
REQ-029 Latency: a command pulse in cycle N SHALL set running=1 in cycle N+1; the first phase change follows DIV cycles later.

Reset
REQ-030 While reset=0, the block SHALL force the following, including mid-instruction: IDLE, p0, step 0, wclk=1, wclkd=0, wclke=1, wclks=0, bos=100000, running=0, icount=0, prescaler=0.
REQ-031 After reset release, the block SHALL remain IDLE until a command is given.

Structure
REQ-032 The FSM state encoding and the phase-to-(wclk,wclkd) table SHALL reside in a shared package jcpu_pkg.
REQ-033 The block SHALL instantiate one sub-module, jphase_gen: prescaler plus 2-bit phase counter with advance enable, emitting a p3->p0 wrap strobe.
REQ-034 The step counter, FSM and icount SHALL reside in jstep_ctl.

Verification
REQ-035 Reset then start with DIV=1: 24 clocks -> bos walks 100000..000001, back to 100000, icount=1; phases repeat (1,0),(1,1),(0,1),(0,0).
REQ-036 step_cycle from IDLE at step 0, DIV=2: 8 clocks of phase activity -> IDLE, bos=010000, icount=0, running=0.
REQ-037 stop during step 3 in RUN -> completes steps 3..6, then IDLE at bos=100000, icount incremented by 1.
REQ-038 halt held at 1 in RUN -> IDLE at the next boundary; start while halt=1 -> stays IDLE.
REQ-039 reset=0 asserted mid-step 4 at p2 -> outputs go to the reset values of REQ-030 without waiting for clk.
REQ-040 Preload icount=0xFFFF via 65535 instructions, then step_instr -> icount=0x0000, IDLE, bos=100000.
